// File: rtl/hrange_arbiter.sv
// hrange_arbiter: shares one hrange generator core among NUM_REQ requesters.
// Start pulses are captured per requester and served in round-robin order.
// The winner's arguments are launched into the core. The core's stream and
// done pulse are routed back to the winner only, and the winner's pause is
// routed forward to the core.
module hrange_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int GRANT_W = 2
) (
   input  logic                      _clock,
   input  logic                      _reset,
   input  logic [NUM_REQ-1:0]        req_start,
   input  logic [32*NUM_REQ-1:0]     req_base,
   input  logic [32*NUM_REQ-1:0]     req_limit,
   input  logic [32*NUM_REQ-1:0]     req_step,
   input  logic [NUM_REQ-1:0]        req_wait,
   output logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic signed [31:0]        req_0,
   output logic [GRANT_W-1:0]        grant_id,
   output logic                      busy,
   output logic signed [31:0]        gen_base,
   output logic signed [31:0]        gen_limit,
   output logic signed [31:0]        gen_step,
   output logic                      gen_start,
   output logic                      gen_wait,
   output logic                      gen_reset,
   input  logic                      gen_valid,
   input  logic                      gen_ready,
   input  logic signed [31:0]        gen_0
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t state, state_next;

   logic [NUM_REQ-1:0]  pending;
   logic [GRANT_W-1:0]  rr_ptr;
   logic signed [31:0]  arg_base  [NUM_REQ];
   logic signed [31:0]  arg_limit [NUM_REQ];
   logic signed [31:0]  arg_step  [NUM_REQ];

   logic [NUM_REQ-1:0]  candidates;
   logic                pick_found;
   logic [GRANT_W-1:0]  pick_idx;
   logic [GRANT_W:0]    scan_idx;
   logic [NUM_REQ-1:0]  pick_mask;
   logic                launch;
   logic                stream_done;
   logic signed [31:0]  sel_base, sel_limit, sel_step;

   // The core is held in reset exactly when the arbiter is, so a reset mid-stream aborts it too
   assign gen_reset = _reset;

   assign candidates  = pending | req_start;
   assign launch      = (state == IDLE) && pick_found;
   assign stream_done = (state == RUN) && gen_ready;

   // Round-robin search: scan offsets from the highest down so the lowest offset from rr_ptr wins
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      scan_idx   = '0;
      pick_mask  = '0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         scan_idx = {1'b0, rr_ptr} + (GRANT_W + 1)'(off);
         if (scan_idx >= (GRANT_W + 1)'(NUM_REQ)) begin
            scan_idx = scan_idx - (GRANT_W + 1)'(NUM_REQ);
         end
         if (candidates[scan_idx[GRANT_W-1:0]]) begin
            pick_found = 1'b1;
            pick_idx   = scan_idx[GRANT_W-1:0];
         end
      end
      if (pick_found) begin
         pick_mask[pick_idx] = 1'b1;
      end
   end

   // A start pulse arriving on the launch edge bypasses the latches so its fresh arguments are used
   always_comb begin
      sel_base  = arg_base[pick_idx];
      sel_limit = arg_limit[pick_idx];
      sel_step  = arg_step[pick_idx];
      if (req_start[pick_idx]) begin
         sel_base  = req_base[32*pick_idx +: 32];
         sel_limit = req_limit[32*pick_idx +: 32];
         sel_step  = req_step[32*pick_idx +: 32];
      end
   end

   // State register
   always_ff @(posedge _clock) begin
      if (_reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: launch whenever something is waiting, return to IDLE on the core's done pulse
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (pick_found) state_next = RUN;
         RUN:     if (gen_ready)  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output routing: only the granted requester sees the stream, and only its pause reaches the core
   always_comb begin
      req_valid = '0;
      req_ready = '0;
      gen_wait  = 1'b0;
      req_0     = gen_0;
      busy      = (state == RUN);
      if (state == RUN) begin
         req_valid[grant_id] = gen_valid;
         req_ready[grant_id] = gen_ready;
         gen_wait            = req_wait[grant_id];
      end
   end

   // Per-requester argument latches; the latest start pulse overwrites earlier arguments
   always_ff @(posedge _clock) begin
      if (_reset) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            arg_base[i]  <= '0;
            arg_limit[i] <= '0;
            arg_step[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_start[i]) begin
               arg_base[i]  <= req_base[32*i +: 32];
               arg_limit[i] <= req_limit[32*i +: 32];
               arg_step[i]  <= req_step[32*i +: 32];
            end
         end
      end
   end

   // Grant bookkeeping: pending set, launch of the chosen requester, and round-robin pointer advance
   always_ff @(posedge _clock) begin
      if (_reset) begin
         pending   <= '0;
         rr_ptr    <= '0;
         grant_id  <= '0;
         gen_start <= 1'b0;
         gen_base  <= '0;
         gen_limit <= '0;
         gen_step  <= '0;
      end else begin
         pending   <= (pending | req_start) & ~(launch ? pick_mask : '0);
         gen_start <= launch;
         if (launch) begin
            grant_id  <= pick_idx;
            gen_base  <= sel_base;
            gen_limit <= sel_limit;
            gen_step  <= sel_step;
         end
         if (stream_done) begin
            rr_ptr <= (grant_id == GRANT_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hrange_arbiter.sv
// tb_hrange_arbiter: directed test of the hrange arbiter.
// A behavioural hrange core answers the arbiter's launches. A negedge
// monitor records the values each requester accepts and the done pulses
// each requester receives.
module tb_hrange_arbiter;

   localparam int N = 4;

   logic                _clock = 1'b0;
   logic                _reset = 1'b1;
   logic [N-1:0]        req_start = '0;
   logic [32*N-1:0]     req_base  = '0;
   logic [32*N-1:0]     req_limit = '0;
   logic [32*N-1:0]     req_step  = '0;
   logic [N-1:0]        req_wait  = '0;
   logic [N-1:0]        req_valid;
   logic [N-1:0]        req_ready;
   logic signed [31:0]  req_0;
   logic [1:0]          grant_id;
   logic                busy;
   logic signed [31:0]  gen_base, gen_limit, gen_step;
   logic                gen_start, gen_wait, gen_reset;
   logic                gen_valid, gen_ready;
   logic signed [31:0]  gen_0;

   int tests  = 0;
   int failed = 0;

   int    got [N][$];
   int    ready_cnt [N];
   string ready_log;
   int    overlap;

   logic               m_active;
   logic signed [31:0] m_cur, m_lim, m_stp;

   hrange_arbiter #(.NUM_REQ(N), .GRANT_W(2)) dut (
      ._clock(_clock), ._reset(_reset),
      .req_start(req_start), .req_base(req_base), .req_limit(req_limit), .req_step(req_step),
      .req_wait(req_wait), .req_valid(req_valid), .req_ready(req_ready), .req_0(req_0),
      .grant_id(grant_id), .busy(busy),
      .gen_base(gen_base), .gen_limit(gen_limit), .gen_step(gen_step),
      .gen_start(gen_start), .gen_wait(gen_wait), .gen_reset(gen_reset),
      .gen_valid(gen_valid), .gen_ready(gen_ready), .gen_0(gen_0)
   );

   // Free-running clock
   always #5 _clock = ~_clock;

   // Behavioural hrange core: presents base on launch, advances on each unpaused accepted value
   always @(posedge _clock) begin
      if (gen_reset) begin
         m_active  <= 1'b0;
         gen_valid <= 1'b0;
         gen_ready <= 1'b0;
      end else if (gen_start) begin
         m_lim <= gen_limit;
         m_stp <= gen_step;
         m_cur <= gen_base;
         if (gen_base < gen_limit) begin
            m_active  <= 1'b1;
            gen_valid <= 1'b1;
            gen_0     <= gen_base;
            gen_ready <= 1'b0;
         end else begin
            m_active  <= 1'b0;
            gen_valid <= 1'b0;
            gen_ready <= 1'b1;
         end
      end else begin
         gen_ready <= 1'b0;
         if (m_active && gen_valid && !gen_wait) begin
            if (m_cur + m_stp < m_lim) begin
               m_cur <= m_cur + m_stp;
               gen_0 <= m_cur + m_stp;
            end else begin
               m_active  <= 1'b0;
               gen_valid <= 1'b0;
               gen_ready <= 1'b1;
            end
         end
      end
   end

   // Monitor: record accepted values, done pulses and any overlap on req_valid
   always @(negedge _clock) begin
      if (!_reset) begin
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && !req_wait[i]) got[i].push_back(int'(req_0));
            if (req_ready[i]) begin
               ready_cnt[i]++;
               ready_log = {ready_log, $sformatf("%0d ", i)};
            end
         end
         if ($countones(req_valid) > 1) overlap++;
      end
   end

   function automatic string q2s(input int k);
      string s = "";
      for (int j = 0; j < got[k].size(); j++) s = {s, $sformatf("%0d ", got[k][j])};
      return s;
   endfunction

   task automatic tick();
      @(posedge _clock);
      #1;
   endtask

   task automatic clear_mon();
      for (int i = 0; i < N; i++) begin
         got[i].delete();
         ready_cnt[i] = 0;
      end
      ready_log = "";
   endtask

   task automatic set_args(input int i, input int b, input int l, input int s);
      req_base[32*i +: 32]  = b;
      req_limit[32*i +: 32] = l;
      req_step[32*i +: 32]  = s;
   endtask

   task automatic applyStimulus(input logic [N-1:0] mask);
      req_start = mask;
      tick();
      req_start = '0;
   endtask

   task automatic wait_idle(input string name);
      int quiet = 0;
      int n = 0;
      while (quiet < 2 && n < 200) begin
         @(negedge _clock);
         n++;
         if (!busy) quiet++;
         else quiet = 0;
      end
      tests++;
      if (quiet < 2) begin
         failed++;
         $display("[TB] FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
      end
   endtask

   task automatic test_reset();
      _reset = 1'b1;
      tick(); tick();
      @(negedge _clock);
      tests++; if (gen_reset !== 1'b1) begin failed++; $display("[TB] FAIL rst_gen_reset: got %b want 1", gen_reset); end
      tests++; if (busy !== 1'b0) begin failed++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
      tests++; if (req_valid !== 4'b0 || req_ready !== 4'b0) begin failed++; $display("[TB] FAIL rst_req_out: got %b/%b want 0/0", req_valid, req_ready); end
      tests++; if (gen_start !== 1'b0 || grant_id !== 2'd0) begin failed++; $display("[TB] FAIL rst_grant: got start=%b id=%0d want 0/0", gen_start, grant_id); end
      tests++; if (gen_base !== 32'sd0 || gen_limit !== 32'sd0 || gen_step !== 32'sd0) begin failed++; $display("[TB] FAIL rst_args: got %0d/%0d/%0d want 0/0/0", gen_base, gen_limit, gen_step); end
      tests++; if (dut.pending !== 4'b0 || dut.rr_ptr !== 2'd0) begin failed++; $display("[TB] FAIL rst_state: got pend=%b rr=%0d want 0/0", dut.pending, dut.rr_ptr); end
      #1 _reset = 1'b0;
      tick();
      @(negedge _clock);
      tests++; if (gen_reset !== 1'b0) begin failed++; $display("[TB] FAIL rst_release: got %b want 0", gen_reset); end
   endtask

   task automatic test_single();
      clear_mon();
      tick();
      set_args(0, 0, 5, 1);
      applyStimulus(4'b0001);
      @(negedge _clock);
      tests++; if (gen_start !== 1'b1 || busy !== 1'b1) begin failed++; $display("[TB] FAIL single_launch: got start=%b busy=%b want 1/1", gen_start, busy); end
      tests++; if (gen_base !== 32'sd0 || gen_limit !== 32'sd5 || gen_step !== 32'sd1) begin failed++; $display("[TB] FAIL single_args: got %0d/%0d/%0d want 0/5/1", gen_base, gen_limit, gen_step); end
      tick();
      @(negedge _clock);
      tests++; if (req_valid !== 4'b0001 || req_0 !== 32'sd0 || gen_start !== 1'b0) begin failed++; $display("[TB] FAIL single_first: got valid=%b data=%0d start=%b want 0001/0/0", req_valid, req_0, gen_start); end
      wait_idle("single");
      tests++; if (q2s(0) != "0 1 2 3 4 ") begin failed++; $display("[TB] FAIL single_data: got '%s' want '0 1 2 3 4 '", q2s(0)); end
      tests++; if (ready_log != "0 ") begin failed++; $display("[TB] FAIL single_ready: got '%s' want '0 '", ready_log); end
      tests++; if (grant_id !== 2'd0 || busy !== 1'b0 || dut.rr_ptr !== 2'd1) begin failed++; $display("[TB] FAIL single_end: got id=%0d busy=%b rr=%0d want 0/0/1", grant_id, busy, dut.rr_ptr); end
   endtask

   task automatic test_simultaneous();
      clear_mon();
      tick();
      set_args(1, 0, 3, 1);
      set_args(3, 10, 12, 1);
      applyStimulus(4'b1010);
      @(negedge _clock);
      tests++; if (grant_id !== 2'd1 || gen_limit !== 32'sd3) begin failed++; $display("[TB] FAIL simul_first_grant: got id=%0d limit=%0d want 1/3", grant_id, gen_limit); end
      wait_idle("simul");
      tests++; if (q2s(1) != "0 1 2 ") begin failed++; $display("[TB] FAIL simul_req1: got '%s' want '0 1 2 '", q2s(1)); end
      tests++; if (q2s(3) != "10 11 ") begin failed++; $display("[TB] FAIL simul_req3: got '%s' want '10 11 '", q2s(3)); end
      tests++; if (ready_log != "1 3 ") begin failed++; $display("[TB] FAIL simul_order: got '%s' want '1 3 '", ready_log); end
      tests++; if (dut.rr_ptr !== 2'd0) begin failed++; $display("[TB] FAIL simul_rr: got %0d want 0", dut.rr_ptr); end
   endtask

   task automatic test_rr_wrap();
      clear_mon();
      tick();
      set_args(2, 0, 1, 1);
      applyStimulus(4'b0100);
      wait_idle("wrap_setup");
      tests++; if (dut.rr_ptr !== 2'd3) begin failed++; $display("[TB] FAIL wrap_rr_setup: got %0d want 3", dut.rr_ptr); end
      clear_mon();
      tick();
      set_args(0, 20, 22, 1);
      set_args(3, 30, 31, 1);
      applyStimulus(4'b1001);
      wait_idle("wrap");
      tests++; if (ready_log != "3 0 ") begin failed++; $display("[TB] FAIL wrap_order: got '%s' want '3 0 '", ready_log); end
      tests++; if (q2s(3) != "30 " || q2s(0) != "20 21 ") begin failed++; $display("[TB] FAIL wrap_data: got '%s'|'%s' want '30 '|'20 21 '", q2s(3), q2s(0)); end
   endtask

   task automatic test_backpressure();
      int n = 0;
      clear_mon();
      tick();
      req_wait = 4'b0100;
      set_args(0, 0, 4, 1);
      applyStimulus(4'b0001);
      do begin
         @(negedge _clock);
         n++;
      end while (req_valid[0] !== 1'b1 && n < 10);
      tests++; if (req_valid[0] !== 1'b1) begin failed++; $display("[TB] FAIL bp_first_valid: got %b want 1", req_valid[0]); end
      tick();
      req_wait[0] = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge _clock);
         tests++; if (gen_wait !== 1'b1) begin failed++; $display("[TB] FAIL bp_wait_c%0d: got %b want 1", c, gen_wait); end
         tick();
      end
      req_wait[0] = 1'b0;
      @(negedge _clock);
      tests++; if (gen_wait !== 1'b0) begin failed++; $display("[TB] FAIL bp_foreign_wait: got %b want 0", gen_wait); end
      wait_idle("bp");
      req_wait = '0;
      tests++; if (q2s(0) != "0 1 2 3 ") begin failed++; $display("[TB] FAIL bp_data: got '%s' want '0 1 2 3 '", q2s(0)); end
      tests++; if (ready_cnt[0] != 1) begin failed++; $display("[TB] FAIL bp_ready: got %0d want 1", ready_cnt[0]); end
   endtask

   task automatic test_empty_rerequest();
      int n = 0;
      clear_mon();
      tick();
      set_args(2, 5, 5, 1);
      req_start = 4'b0100;
      tick();
      set_args(2, 0, 2, 1);
      tick();
      req_start = '0;
      while (ready_cnt[2] == 0 && n < 10) begin
         @(negedge _clock);
         n++;
      end
      tests++; if (ready_cnt[2] != 1 || got[2].size() != 0) begin failed++; $display("[TB] FAIL empty_first: got ready=%0d valids=%0d want 1/0", ready_cnt[2], got[2].size()); end
      wait_idle("empty");
      tests++; if (ready_cnt[2] != 2) begin failed++; $display("[TB] FAIL empty_requeue_ready: got %0d want 2", ready_cnt[2]); end
      tests++; if (q2s(2) != "0 1 ") begin failed++; $display("[TB] FAIL empty_requeue_data: got '%s' want '0 1 '", q2s(2)); end
   endtask

   task automatic test_reset_midrun();
      int n = 0;
      clear_mon();
      tick();
      set_args(0, 0, 10, 1);
      applyStimulus(4'b0001);
      set_args(1, 0, 3, 1);
      applyStimulus(4'b0010);
      do begin
         @(negedge _clock);
         n++;
      end while (!(req_valid[0] === 1'b1 && req_0 === 32'sd1) && n < 10);
      tests++; if (req_0 !== 32'sd1) begin failed++; $display("[TB] FAIL mid_second_value: got %0d want 1", req_0); end
      tests++; if (dut.pending !== 4'b0010) begin failed++; $display("[TB] FAIL mid_pending: got %b want 0010", dut.pending); end
      #1 _reset = 1'b1;
      #1;
      tests++; if (gen_reset !== 1'b1) begin failed++; $display("[TB] FAIL mid_gen_reset: got %b want 1", gen_reset); end
      tick();
      tests++; if (busy !== 1'b0 || req_valid !== 4'b0 || req_ready !== 4'b0) begin failed++; $display("[TB] FAIL mid_outputs: got busy=%b valid=%b ready=%b want 0", busy, req_valid, req_ready); end
      tests++; if (gen_start !== 1'b0 || grant_id !== 2'd0 || gen_base !== 32'sd0 || gen_limit !== 32'sd0) begin failed++; $display("[TB] FAIL mid_regs: got start=%b id=%0d base=%0d lim=%0d want 0", gen_start, grant_id, gen_base, gen_limit); end
      tests++; if (dut.pending !== 4'b0) begin failed++; $display("[TB] FAIL mid_pending_clr: got %b want 0", dut.pending); end
      _reset = 1'b0;
      repeat (6) @(negedge _clock);
      tests++; if (ready_cnt[0] != 0 || ready_cnt[1] != 0 || busy !== 1'b0) begin failed++; $display("[TB] FAIL mid_after: got r0=%0d r1=%0d busy=%b want 0/0/0", ready_cnt[0], ready_cnt[1], busy); end
   endtask

   // Test sequence
   initial begin
      overlap = 0;
      clear_mon();
      test_reset();
      test_single();
      test_simultaneous();
      test_rr_wrap();
      test_backpressure();
      test_empty_rerequest();
      test_reset_midrun();
      tests++; if (overlap != 0) begin failed++; $display("[TB] FAIL valid_overlap: got %0d cycles want 0", overlap); end
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/hrange_arbiter.md
Name: hrange_arbiter

Overview:
- Shares one hrange generator instance among NUM_REQ requesters, each supplying its own base/limit/step.
- Captures start pulses and picks requesters round-robin.
- Launches the generator with the chosen arguments and routes its output stream and backpressure to and from the granted requester.
- Sits between software-derived generator callers and a single physical hrange core.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GRANT_W, 2, grant index width = clog2(NUM_REQ).

Ports:
- _clock  in  1  single clock, rising edge.
- _reset  in  1  synchronous, active-high reset.
- req_start  in  NUM_REQ  per-requester start pulse, args sampled same edge.
- req_base  in  32*NUM_REQ  signed base, slice i = requester i.
- req_limit  in  32*NUM_REQ  signed limit.
- req_step  in  32*NUM_REQ  signed step.
- req_wait  in  NUM_REQ  per-requester pause.
- req_valid  out  NUM_REQ  output valid, only granted bit can be high.
- req_ready  out  NUM_REQ  one-cycle done pulse to granted requester.
- req_0  out  32  shared signed data bus, meaningful when a req_valid bit is high.
- grant_id  out  GRANT_W  current or last granted requester.
- busy  out  1  high while in RUN.
- gen_base, gen_limit, gen_step  out  32 each  registered args to generator.
- gen_start  out  1  registered one-cycle launch pulse.
- gen_wait  out  1  backpressure to generator.
- gen_reset  out  1  generator reset.
- gen_valid  in  1  generator output valid.
- gen_ready  in  1  generator done pulse.
- gen_0  in  32  generator data.

Behaviour:
- Reset values:
  - State IDLE; pending = 0; rr_ptr = 0; grant_id = 0.
  - gen_start = 0; gen_base/limit/step = 0 and all argument latches = 0.
  - req_valid = 0, req_ready = 0, busy = 0.
- gen_reset = _reset (combinational passthrough). Reset mid-RUN aborts the stream: no req_ready pulse, all pending requests dropped.
- Argument capture: req_start[i] at an edge latches requester i's base/limit/step into per-requester regs and sets pending[i]. A re-pulse while pending overwrites the args; the latest pulse wins.
- IDLE:
  - Candidates = pending | req_start (bypass).
  - Pick the first set bit searching from rr_ptr upward, with wrap.
  - On a pick: grant_id <= k; gen_* <= k's args (the bypass values if arriving this edge); gen_start <= 1; pending[k] <= 0; state <= RUN.
  - With no candidate, stay in IDLE.
- RUN:
  - gen_start <= 0 after its single cycle.
  - gen_wait = req_wait[grant_id]; req_valid[grant_id] = gen_valid; req_0 = gen_0.
  - req_ready[grant_id] = gen_ready, all combinational; all other bits 0.
  - gen_ready sampled high -> state <= IDLE; rr_ptr <= (grant_id+1) mod NUM_REQ.
- Outside RUN: gen_wait = 0, req_valid = 0, req_ready = 0, req_0 = gen_0 (don't care).
- busy = (state == RUN).
- Latency:
  - req_start at edge t with the arbiter idle -> gen_start high in cycle t..t+1 -> generator samples at edge t+1 -> first req_valid after edge t+1, assuming the generator is not waited.
  - One bubble cycle in IDLE between gen_ready and the next launch.
- req_start for the currently granted requester during RUN: args latched, pending set, served after the current stream completes in round-robin order. The current stream is not disturbed.
- Empty range (base >= limit): the generator answers with gen_ready and no valid. The requester gets exactly one req_ready pulse and zero req_valid.
- Backpressure: while req_wait[grant_id] = 1 the generator holds. The arbiter never drops or duplicates values. Waits from non-granted requesters are ignored.
- Fairness: a requester pending continuously is served within NUM_REQ grants.
- No arithmetic in the arbiter. Data passes 32-bit signed unchanged.

Test Plan:
- Single request: req_start[0] with base=0, limit=5, step=1 -> req_valid[0] carries 0,1,2,3,4 on req_0, then one req_ready[0] pulse; grant_id=0; busy low afterwards; rr_ptr=1.
- Simultaneous requests: req_start = 4'b1010 with req1 = (0,3,1) and req3 = (10,12,1) -> req1 streams 0,1,2 then ready, one IDLE bubble, req3 streams 10,11 then ready; no overlap on req_valid.
- Round-robin wrap: rr_ptr=3 and requests on 0 and 3 -> 3 served first, then 0.
- Backpressure: req_wait[0] held high for 3 cycles mid-stream on (0,4,1) -> gen_wait high those cycles; output sequence still exactly 0,1,2,3; a wait on a non-granted requester has no effect.
- Empty range and re-request: req2 with (5,5,1) -> zero valids, one req_ready[2]. A req_start[2] during RUN with (0,2,1) is queued -> 0,1 after the current stream.
- Reset mid-run: _reset asserted during the 2nd value of (0,10,1) -> gen_reset high same cycle; next cycle state IDLE, all outputs 0, pending cleared, no req_ready pulse.
